// File: rtl/mul_share_arbiter.sv
// ---------------------------------------------------------------------------
// mul_share_arbiter
//   Round-robin arbiter sharing one registered two-stage N x N multiplier
//   (input regs -> combinational core -> output regs, common enable) between
//   two requesters. Operands are muxed in, the multiplier enable is used as a
//   pipeline stall, a shadow pipeline tracks the owner of each in-flight
//   product, and results are steered back with valid/ready backpressure.
//
// Ports
//   clk, reset            rising-edge clock, async active-high reset
//   req_valid/req_ready   per-requester operand handshake (bit i = requester i)
//   req_a0/req_b0         requester 0 operands
//   req_a1/req_b1         requester 1 operands
//   rsp_valid/rsp_ready   per-requester result handshake
//   rsp_data              product, passed through from mul_result
//   mul_a/mul_b/mul_en    operands and enable driven to the multiplier
//   mul_result            multiplier output-register value
//   inflight              number of occupied pipeline stages (0..2)
// ---------------------------------------------------------------------------
module mul_share_arbiter #(
  parameter int N = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [N-1:0]     req_a0,
  input  logic [N-1:0]     req_b0,
  input  logic [N-1:0]     req_a1,
  input  logic [N-1:0]     req_b1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [2*N-1:0]   rsp_data,
  output logic [N-1:0]     mul_a,
  output logic [N-1:0]     mul_b,
  output logic             mul_en,
  input  logic [2*N-1:0]   mul_result,
  output logic [1:0]       inflight
);

  // Shadow of the multiplier stages: valid flag and owning requester id.
  logic r_v1, r_t1;   // input-register stage
  logic r_v2, r_t2;   // output-register stage
  logic r_rr;         // favoured requester

  logic w_adv;
  logic w_gnt;        // a grant occurs this cycle
  logic w_gnt_id;

  // The pipeline moves whenever the output stage is empty or its owner
  // takes the result; the other requester's rsp_ready is irrelevant.
  assign w_adv  = !r_v2 || rsp_ready[r_t2];
  assign mul_en = w_adv;

  // NOTE: every signal written in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_gnt    = 1'b0;
    w_gnt_id = 1'b0;
    if (w_adv) begin
      if (req_valid[r_rr]) begin
        w_gnt    = 1'b1;
        w_gnt_id = r_rr;
      end else if (req_valid[!r_rr]) begin
        w_gnt    = 1'b1;
        w_gnt_id = !r_rr;
      end
    end
  end

  always_comb begin
    req_ready = 2'b00;
    mul_a     = '0;
    mul_b     = '0;
    if (w_gnt) begin
      req_ready[w_gnt_id] = 1'b1;
      mul_a = w_gnt_id ? req_a1 : req_a0;
      mul_b = w_gnt_id ? req_b1 : req_b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, matching the multiplier's own registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v1 <= 1'b0;
      r_t1 <= 1'b0;
      r_v2 <= 1'b0;
      r_t2 <= 1'b0;
      r_rr <= 1'b0;
    end else if (w_adv) begin
      r_v2 <= r_v1;
      r_t2 <= r_t1;
      r_v1 <= w_gnt;
      r_t1 <= w_gnt_id;
      if (w_gnt) r_rr <= !w_gnt_id;
    end
  end

  always_comb begin
    rsp_valid        = 2'b00;
    rsp_valid[r_t2]  = r_v2;
  end

  assign rsp_data = mul_result;
  assign inflight = {1'b0, r_v1} + {1'b0, r_v2};

endmodule

// File: tb/tb_mul_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mul_share_arbiter
//   Drives the arbiter with directed scenarios and random traffic. A simple
//   two-stage enabled multiplier model stands in for the shared multiplier.
//   A reference model holds the in-flight products as a two-entry queue
//   (front = result visible to requesters) plus the favoured-requester bit,
//   and one process compares every DUT output against it on each falling
//   edge. Directed scenarios also pin literal expected values.
// ---------------------------------------------------------------------------
module tb_mul_share_arbiter;

  localparam int N = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [N-1:0]    req_a0, req_b0, req_a1, req_b1;
  logic [1:0]      rsp_valid;
  logic [1:0]      rsp_ready;
  logic [2*N-1:0]  rsp_data;
  logic [N-1:0]    mul_a, mul_b;
  logic            mul_en;
  logic [2*N-1:0]  mul_result;
  logic [1:0]      inflight;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mul_share_arbiter #(.N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a0     (req_a0),
    .req_b0     (req_b0),
    .req_a1     (req_a1),
    .req_b1     (req_b1),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_en     (mul_en),
    .mul_result (mul_result),
    .inflight   (inflight)
  );

  // Shared multiplier: input registers, core, output registers, one enable.
  logic [N-1:0]   env_a, env_b;
  logic [2*N-1:0] env_p;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      env_a <= '0;
      env_b <= '0;
      env_p <= '0;
    end else if (mul_en) begin
      env_a <= mul_a;
      env_b <= mul_b;
      env_p <= {{N{1'b0}}, env_a} * {{N{1'b0}}, env_b};
    end
  end
  assign mul_result = env_p;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          v;
    bit          tag;
    logic [63:0] prod;
  } entry_t;

  entry_t mq[$];   // mq[0] = result stage, mq[1] = stage behind it
  bit     m_rr;

  always @(negedge clk) begin
    entry_t      e;
    bit          adv, gv, g;
    logic [1:0]  exp_ready, exp_valid;
    logic [31:0] ga, gb;
    if (reset) begin
      mq.delete();
      e = '{v: 1'b0, tag: 1'b0, prod: 64'd0};
      mq.push_back(e);
      mq.push_back(e);
      m_rr = 1'b0;
    end
    if (mq.size() == 2) begin
      adv = !mq[0].v || rsp_ready[mq[0].tag];
      gv = 1'b0; g = 1'b0;
      if (adv) begin
        if (req_valid[m_rr])       begin gv = 1'b1; g = m_rr;  end
        else if (req_valid[!m_rr]) begin gv = 1'b1; g = !m_rr; end
      end
      ga = gv ? (g ? req_a1 : req_a0) : 32'd0;
      gb = gv ? (g ? req_b1 : req_b0) : 32'd0;
      exp_ready = gv ? (g ? 2'b10 : 2'b01) : 2'b00;
      exp_valid = mq[0].v ? (mq[0].tag ? 2'b10 : 2'b01) : 2'b00;
      check("m_req_ready", {62'd0, req_ready}, {62'd0, exp_ready});
      check("m_rsp_valid", {62'd0, rsp_valid}, {62'd0, exp_valid});
      check("m_mul_en",    {63'd0, mul_en},    {63'd0, adv});
      check("m_inflight",  {62'd0, inflight},  64'(int'(mq[0].v) + int'(mq[1].v)));
      check("m_mul_a",     {32'd0, mul_a},     {32'd0, ga});
      check("m_mul_b",     {32'd0, mul_b},     {32'd0, gb});
      if (mq[0].v) check("m_rsp_data", rsp_data, mq[0].prod);
      // Inputs are held until after the next rising edge, so the model can
      // step now and be ready for the next comparison.
      if (!reset && adv) begin
        void'(mq.pop_front());
        e = '{v: gv, tag: g, prod: {32'd0, ga} * {32'd0, gb}};
        mq.push_back(e);
        if (gv) m_rr = !g;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 2'b00;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    rsp_ready = 2'b11;
    idle_inputs();
    #3;
    check("rst_rsp_valid", {62'd0, rsp_valid}, 64'd0);
    check("rst_mul_en",    {63'd0, mul_en},    64'd1);
    check("rst_inflight",  {62'd0, inflight},  64'd0);
    check("rst_ready_idle",{62'd0, req_ready}, 64'd0);
    req_valid = 2'b10;
    #1 check("rst_ready_r1", {62'd0, req_ready}, 64'd2);
    req_valid = 2'b11;
    #1 check("rst_ready_r0", {62'd0, req_ready}, 64'd1);
    tick();
    tick();
    reset = 1'b0;
    idle_inputs();
    tick();

    // Single request from requester 0.
    req_valid = 2'b01; req_a0 = 32'd3; req_b0 = 32'd5;
    #3 check("single_ready", {62'd0, req_ready}, 64'd1);
    tick(); idle_inputs();
    #3 check("single_infl1", {62'd0, inflight}, 64'd1);
    tick();
    #3 check("single_valid", {62'd0, rsp_valid}, 64'd1);
    check("single_data", rsp_data, 64'd15);
    tick();
    #3 check("single_empty", {62'd0, rsp_valid}, 64'd0);
    check("single_infl0", {62'd0, inflight}, 64'd0);

    // Maximum operands from requester 1.
    tick();
    req_valid = 2'b10; req_a1 = 32'hFFFF_FFFF; req_b1 = 32'hFFFF_FFFF;
    tick(); idle_inputs();
    tick();
    #3 check("max_valid", {62'd0, rsp_valid}, 64'd2);
    check("max_data", rsp_data, 64'hFFFF_FFFE_0000_0001);
    tick();
    tick();

    // Contention: both valid for four cycles, rr = 0 here.
    for (int c = 0; c < 6; c++) begin
      if (c < 4) begin
        req_valid = 2'b11;
        req_a0 = 32'(c); req_b0 = 32'd2;
        req_a1 = 32'(c); req_b1 = 32'd3;
      end else begin
        idle_inputs();
      end
      #3;
      if (c < 4)
        check("cont_grant", {62'd0, req_ready}, (c % 2 == 0) ? 64'd1 : 64'd2);
      if (c >= 2) begin
        check("cont_tag",  {62'd0, rsp_valid}, ((c - 2) % 2 == 0) ? 64'd1 : 64'd2);
        check("cont_data", rsp_data, 64'((c - 2) * (((c - 2) % 2 == 0) ? 2 : 3)));
      end
      tick();
    end
    #3 check("cont_drained", {62'd0, inflight}, 64'd0);
    tick();

    // Backpressure on requester 0's result.
    rsp_ready = 2'b10;
    req_valid = 2'b01; req_a0 = 32'd7; req_b0 = 32'd6;
    tick();
    req_valid = 2'b10; req_a1 = 32'd4; req_b1 = 32'd5;
    tick();
    req_valid = 2'b11;
    for (int c = 0; c < 3; c++) begin
      #3;
      check("bp_mul_en", {63'd0, mul_en},    64'd0);
      check("bp_ready",  {62'd0, req_ready}, 64'd0);
      check("bp_valid",  {62'd0, rsp_valid}, 64'd1);
      check("bp_data",   rsp_data,           64'd42);
      check("bp_infl",   {62'd0, inflight},  64'd2);
      tick();
    end
    rsp_ready = 2'b11; idle_inputs();
    tick();
    #3 check("bp_next_valid", {62'd0, rsp_valid}, 64'd2);
    check("bp_next_data", rsp_data, 64'd20);
    tick();
    tick();

    // Same-cycle consume and accept.
    req_valid = 2'b01; req_a0 = 32'd2; req_b0 = 32'd2;
    tick();
    req_a0 = 32'd3; req_b0 = 32'd3;
    tick();
    req_valid = 2'b10; req_a1 = 32'd9; req_b1 = 32'd9;
    #3 check("cc_ready", {62'd0, req_ready}, 64'd2);
    check("cc_infl", {62'd0, inflight}, 64'd2);
    tick(); idle_inputs();
    #3 check("cc_infl_after", {62'd0, inflight}, 64'd2);
    for (int c = 0; c < 3; c++) tick();

    // Reset with two products in flight.
    req_valid = 2'b01; req_a0 = 32'd11; req_b0 = 32'd11;
    tick();
    req_valid = 2'b10; req_a1 = 32'd12; req_b1 = 32'd12;
    tick();
    idle_inputs();
    #1 check("rm_infl_before", {62'd0, inflight}, 64'd2);
    reset = 1'b1;
    req_valid = 2'b11;
    #1;
    check("rm_valid",    {62'd0, rsp_valid}, 64'd0);
    check("rm_inflight", {62'd0, inflight},  64'd0);
    check("rm_rr",       {62'd0, req_ready}, 64'd1);
    tick();
    reset = 1'b0; idle_inputs();
    for (int c = 0; c < 4; c++) begin
      #3 check("rm_no_stale", {62'd0, rsp_valid}, 64'd0);
      tick();
    end

    // Random traffic, checked by the model every cycle.
    for (int c = 0; c < 600; c++) begin
      req_valid = 2'($urandom_range(0, 3));
      req_a0 = $urandom; req_b0 = $urandom;
      req_a1 = $urandom; req_b1 = $urandom;
      rsp_ready = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      reset = ($urandom_range(0, 149) == 0);
      tick();
    end
    reset = 1'b0;
    idle_inputs();
    rsp_ready = 2'b11;
    tick();
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
